// File: rtl/fifo_grant_sched.sv
// fifo_grant_sched: four-requester scheduler that serves rising requests in
// arrival order with a one-hot grant, a bounded tenure and a forced idle
// cycle between tenures.
module fifo_grant_sched #(
   parameter int unsigned HOLD_MAX = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [3:0] grant,
   output logic [1:0] owner,
   output logic       busy,
   output logic [2:0] qcount,
   output logic       timeout
);

   typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

   localparam logic [7:0] HoldLast = 8'(HOLD_MAX - 1);

   state_e     st_q, st_d;
   logic [1:0] fifo_q [4];
   logic [1:0] fifo_d [4];
   logic [2:0] count_q, count_d;
   logic [3:0] req_q;
   logic [3:0] pend_q, pend_d;
   logic [1:0] owner_q, owner_d;
   logic [7:0] hold_q, hold_d;
   logic       timeout_q, timeout_d;
   logic [3:0] new_req;
   logic [3:0] pend_clr;
   logic       pop;
   logic [1:0] head;

   // Queue update: pop uses pre-edge contents, then new requests are appended
   // lowest index first.
   always_comb begin
      new_req = req & ~req_q & ~pend_q;
      head    = fifo_q[0];
      pop     = (st_q != StGrant) && (count_q != 3'd0);
      fifo_d  = fifo_q;
      count_d = count_q;
      if (pop) begin
         for (int i = 0; i < 3; i++) fifo_d[i] = fifo_q[i + 1];
         fifo_d[3] = 2'd0;
         count_d   = count_q - 3'd1;
      end
      // One entry per requester and depth 4, so count_d never exceeds 4 here.
      for (int i = 0; i < 4; i++) begin
         if (new_req[i]) begin
            fifo_d[count_d[1:0]] = 2'(i);
            count_d              = count_d + 3'd1;
         end
      end
   end

   // Tenure FSM: start from the queue head, end on request drop or hold limit.
   always_comb begin
      st_d      = st_q;
      owner_d   = owner_q;
      hold_d    = hold_q;
      timeout_d = 1'b0;
      pend_clr  = 4'b0000;
      case (st_q)
         StIdle, StGap: begin
            st_d = StIdle;
            if (pop) begin
               if (req[head]) begin
                  st_d    = StGrant;
                  owner_d = head;
                  hold_d  = 8'd0;
               end else begin
                  // Stale entry: requester gave up before its turn.
                  pend_clr[head] = 1'b1;
               end
            end
         end
         StGrant: begin
            if (!req[owner_q]) begin
               st_d              = StGap;
               pend_clr[owner_q] = 1'b1;
            end else if (hold_q == HoldLast) begin
               st_d              = StGap;
               pend_clr[owner_q] = 1'b1;
               timeout_d         = 1'b1;
            end else begin
               hold_d = hold_q + 8'd1;
            end
         end
         default: st_d = StIdle;
      endcase
      pend_d = (pend_q & ~pend_clr) | new_req;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q      <= StIdle;
         for (int i = 0; i < 4; i++) fifo_q[i] <= 2'd0;
         count_q   <= 3'd0;
         req_q     <= 4'b0000;
         pend_q    <= 4'b0000;
         owner_q   <= 2'd0;
         hold_q    <= 8'd0;
         timeout_q <= 1'b0;
      end else begin
         st_q      <= st_d;
         fifo_q    <= fifo_d;
         count_q   <= count_d;
         req_q     <= req;
         pend_q    <= pend_d;
         owner_q   <= owner_d;
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   assign grant   = (st_q == StGrant) ? (4'b0001 << owner_q) : 4'b0000;
   assign owner   = (st_q == StGrant) ? owner_q : 2'd0;
   assign busy    = |grant;
   assign qcount  = count_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_fifo_grant_sched.sv
// tb_fifo_grant_sched: directed scenarios plus a long random run, each cycle
// compared against a queue-based reference model of the scheduler.
module tb_fifo_grant_sched;

   localparam int unsigned HOLD = 8;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] grant;
   logic [1:0] owner;
   logic       busy;
   logic [2:0] qcount;
   logic       timeout;

   int n_tests = 0;
   int n_fail  = 0;

   fifo_grant_sched #(.HOLD_MAX(HOLD)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .grant   (grant),
      .owner   (owner),
      .busy    (busy),
      .qcount  (qcount),
      .timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a queue of waiting IDs, the current owner (-1 if none)
   // and the number of cycles the owner has held the grant.
   int         mq[$];
   int         m_owner  = -1;
   int         m_len    = 0;
   logic [3:0] m_prev   = 4'b0000;
   logic       m_tout   = 1'b0;

   task automatic model_edge();
      logic [3:0] waiting;
      logic [3:0] nw;
      int         h;
      if (rst) begin
         mq.delete();
         m_owner = -1;
         m_len   = 0;
         m_prev  = 4'b0000;
         m_tout  = 1'b0;
         return;
      end
      waiting = 4'b0000;
      foreach (mq[i]) waiting[mq[i]] = 1'b1;
      if (m_owner >= 0) waiting[m_owner] = 1'b1;
      nw     = req & ~m_prev & ~waiting;
      m_tout = 1'b0;
      if (m_owner >= 0) begin
         if (!req[m_owner]) begin
            m_owner = -1;
         end else if (m_len == int'(HOLD)) begin
            m_owner = -1;
            m_tout  = 1'b1;
         end else begin
            m_len++;
         end
      end else if (mq.size() > 0) begin
         h = mq.pop_front();
         if (req[h]) begin
            m_owner = h;
            m_len   = 1;
         end
      end
      for (int i = 0; i < 4; i++) if (nw[i]) mq.push_back(i);
      m_prev = req;
   endtask

   function automatic logic [10:0] model_vec();
      logic [3:0] g;
      logic [1:0] o;
      g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      o = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
      return {g, o, |g, 3'(mq.size()), m_tout};
   endfunction

   function automatic logic [10:0] dut_vec();
      return {grant, owner, busy, qcount, timeout};
   endfunction

   // Advance one edge, update the model with the values the DUT sampled.
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic settle();
      req = 4'b0000;
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = 4'b1111;
      tick();
      n_tests++;
      if (dut_vec() !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_state: got %b want %b", dut_vec(), 11'd0);
      end
      tick();
      rst = 1'b0;
      req = 4'b0000;
      tick();
      n_tests++;
      if (dut_vec() !== model_vec()) begin
         n_fail++;
         $display("FAIL reset_idle: got %b want %b", dut_vec(), model_vec());
      end
   endtask

   task automatic test_single_hold();
      req = 4'b0100;
      for (int c = 1; c <= 12; c++) begin
         tick();
         n_tests++;
         if (dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL t1_model c%0d: got %b want %b", c, dut_vec(), model_vec());
         end
         if (c == 2) begin
            n_tests++;
            if ({grant, owner} !== {4'b0100, 2'd2}) begin
               n_fail++;
               $display("FAIL t1_grant_start: got %b/%0d want 0100/2", grant, owner);
            end
         end
         if (c == 9 || c == 10 || c == 11) begin
            n_tests++;
            if ({grant, timeout} !== ((c == 9) ? 5'b01000 : (c == 10) ? 5'b00001 : 5'b00000))
            begin
               n_fail++;
               $display("FAIL t1_timeout c%0d: got grant %b timeout %b", c, grant, timeout);
            end
         end
      end
      settle();
   endtask

   task automatic test_simultaneous();
      logic [3:0] want;
      logic [3:0] prev_g;
      int         order[$];
      int         qseq[$];
      int         zeros;
      int         last_q;
      want   = 4'b1011;
      prev_g = 4'b0000;
      zeros  = 0;
      last_q = int'(qcount);
      for (int c = 1; c <= 16; c++) begin
         if (m_owner >= 0 && m_len >= 2) want[m_owner] = 1'b0;
         req = want;
         tick();
         n_tests++;
         if (dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL t2_model c%0d: got %b want %b", c, dut_vec(), model_vec());
         end
         if (grant != 4'b0000 && prev_g == 4'b0000) begin
            if (order.size() > 0) begin
               n_tests++;
               if (zeros !== 1) begin
                  n_fail++;
                  $display("FAIL t2_gap: got %0d idle cycles want 1", zeros);
               end
            end
            order.push_back(int'(owner));
            zeros = 0;
         end else if (grant == 4'b0000 && order.size() > 0) begin
            zeros++;
         end
         if (int'(qcount) != last_q) begin
            qseq.push_back(int'(qcount));
            last_q = int'(qcount);
         end
         prev_g = grant;
      end
      n_tests++;
      if (!(order.size() == 3 && order[0] == 0 && order[1] == 1 && order[2] == 3)) begin
         n_fail++;
         $display("FAIL t2_order: got %p want 0,1,3", order);
      end
      n_tests++;
      if (!(qseq.size() == 4 && qseq[0] == 3 && qseq[1] == 2 && qseq[2] == 1 && qseq[3] == 0))
      begin
         n_fail++;
         $display("FAIL t2_qcount: got %p want 3,2,1,0", qseq);
      end
      settle();
   endtask

   task automatic test_stale_discard();
      logic [3:0] want;
      bit         saw1;
      bit         saw2;
      saw1 = 1'b0;
      saw2 = 1'b0;
      want = 4'b0010;
      for (int c = 1; c <= 12; c++) begin
         if (c == 2) want = 4'b0110;
         if (c == 3) want[2] = 1'b0;
         if (m_owner >= 0 && m_len >= 3) want[m_owner] = 1'b0;
         req = want;
         tick();
         n_tests++;
         if (dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL t3_model c%0d: got %b want %b", c, dut_vec(), model_vec());
         end
         if (grant[1]) saw1 = 1'b1;
         if (grant[2]) saw2 = 1'b1;
      end
      n_tests++;
      if ({saw1, saw2, qcount} !== {1'b1, 1'b0, 3'd0}) begin
         n_fail++;
         $display("FAIL t3_discard: got g1=%b g2=%b q=%0d want 1 0 0", saw1, saw2, qcount);
      end
      settle();
   endtask

   task automatic test_retoggle();
      logic [3:0] want;
      logic [3:0] prev_g;
      int         starts0;
      int         maxq;
      want    = 4'b0000;
      prev_g  = 4'b0000;
      starts0 = 0;
      maxq    = 0;
      for (int c = 1; c <= 24; c++) begin
         case (c)
            1: want = 4'b0010;
            2: want = 4'b1010;
            3: want = 4'b1011;
            default: ;
         endcase
         if (c > 5 && m_owner >= 0 && m_len >= 2) want[m_owner] = 1'b0;
         req = (c == 4) ? (want & 4'b1110) : want;
         tick();
         n_tests++;
         if (dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL t4_model c%0d: got %b want %b", c, dut_vec(), model_vec());
         end
         if (grant[0] && !prev_g[0]) starts0++;
         if (int'(qcount) > maxq) maxq = int'(qcount);
         prev_g = grant;
      end
      n_tests++;
      if (starts0 !== 1 || maxq !== 2) begin
         n_fail++;
         $display("FAIL t4_single_entry: got grants0=%0d maxq=%0d want 1 2", starts0, maxq);
      end
      settle();
   endtask

   task automatic test_reset_mid_tenure();
      req = 4'b0010;
      tick();
      req = 4'b1011;
      tick();
      n_tests++;
      if ({grant, qcount} !== {4'b0010, 3'd2}) begin
         n_fail++;
         $display("FAIL t5_setup: got grant %b q %0d want 0010 2", grant, qcount);
      end
      rst = 1'b1;
      req = 4'b0010;
      tick();
      n_tests++;
      if ({grant, qcount, timeout} !== 8'd0) begin
         n_fail++;
         $display("FAIL t5_reset: got grant %b q %0d to %b want 0", grant, qcount, timeout);
      end
      rst = 1'b0;
      tick();
      n_tests++;
      if ({grant, qcount} !== {4'b0000, 3'd1}) begin
         n_fail++;
         $display("FAIL t5_requeue: got grant %b q %0d want 0000 1", grant, qcount);
      end
      tick();
      n_tests++;
      if (grant !== 4'b0010) begin
         n_fail++;
         $display("FAIL t5_regrant: got %b want 0010", grant);
      end
      settle();
   endtask

   task automatic test_random();
      logic [3:0] prev_g;
      int         run;
      prev_g = 4'b0000;
      run    = 0;
      for (int c = 0; c < 10000; c++) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(7) == 0) req[b] = ~req[b];
         end
         rst = ($urandom_range(1999) == 0);
         tick();
         n_tests++;
         if (dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL rand_model c%0d: got %b want %b", c, dut_vec(), model_vec());
         end
         if (grant == 4'b0000) run = 0;
         else if (grant == prev_g) run++;
         else run = 1;
         n_tests++;
         if (!$onehot0(grant) || run > int'(HOLD)) begin
            n_fail++;
            $display("FAIL rand_invariant c%0d: got grant %b run %0d", c, grant, run);
         end
         prev_g = grant;
      end
      rst = 1'b0;
      settle();
   endtask

   initial begin
      rst = 1'b1;
      req = 4'b0000;
      test_reset();
      test_single_hold();
      test_simultaneous();
      test_stale_discard();
      test_retoggle();
      test_reset_mid_tenure();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
